// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, LSB first, one stop bit.
// The input passes through a 2-flop synchronizer. Each bit is sampled at its
// midpoint, and the stop bit is checked before the word is presented.
//
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit between
// the data bits and the stop bit, and an o_parity_err output.
//
// Ports:
//   i_clk        system clock, all logic on posedge
//   i_reset      asynchronous, active-high reset
//   i_rx         serial input, idle high, asynchronous to i_clk
//   o_data       last correctly received word; holds until the next good frame
//   o_valid      one-cycle pulse when o_data is updated
//   o_frame_err  one-cycle pulse when the stop bit samples low
//   o_parity_err one-cycle pulse with o_valid on a parity mismatch (UART_RX_PARITY_EN only)
//   o_busy       high whenever the receiver is not idle (combinational from state)
module uart_rx #(
    parameter int unsigned CLOCK_RATE     = 50000000,
    parameter int unsigned BAUD_RATE      = 9600,
    parameter int unsigned DATA_BITS      = 8,
    parameter int unsigned CYCLES_PER_BIT = CLOCK_RATE / BAUD_RATE
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 o_parity_err,
`endif
    output logic                 o_busy
);

    localparam int unsigned CNT_W = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
    localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF   = CNT_W'(CYCLES_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_BITS - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY    = 3'd5;
`endif

    logic                 rx_meta;
    logic                 rx_s;
    logic [2:0]           state,     state_nxt;
    logic [CNT_W-1:0]     cnt,       cnt_nxt;
    logic [IDX_W-1:0]     idx,       idx_nxt;
    logic [DATA_BITS-1:0] shift,     shift_nxt;
    logic [DATA_BITS-1:0] data_nxt;
    logic                 valid_nxt;
    logic                 ferr_nxt;
    logic                 tick;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit,   par_nxt;
    logic                 perr_nxt;
`endif

    // Two-flop synchronizer; idles high so reset does not look like a start bit
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    assign tick   = (cnt == '0);
    assign o_busy = (state != ST_IDLE);

    // State and datapath register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            idx          <= '0;
            shift        <= '0;
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit      <= 1'b0;
            o_parity_err <= 1'b0;
`endif
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            idx          <= idx_nxt;
            shift        <= shift_nxt;
            o_data       <= data_nxt;
            o_valid      <= valid_nxt;
            o_frame_err  <= ferr_nxt;
`ifdef UART_RX_PARITY_EN
            par_bit      <= par_nxt;
            o_parity_err <= perr_nxt;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        shift_nxt = shift;
        data_nxt  = o_data;
        valid_nxt = 1'b0;
        ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_nxt   = par_bit;
        perr_nxt  = 1'b0;
`endif

        // Bit-period counter runs only while inside a frame
        if (state != ST_IDLE && state != ST_WAIT_IDLE) begin
            cnt_nxt = tick ? CNT_RELOAD : cnt - CNT_W'(1);
        end

        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_nxt = ST_START;
                    cnt_nxt   = CNT_HALF;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (rx_s) begin
                        state_nxt = ST_IDLE;      // glitch, not a real start bit
                    end else begin
                        state_nxt = ST_DATA;
                        idx_nxt   = '0;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    // Shift right, so the first bit received ends up in bit 0
                    shift_nxt = (shift >> 1) | (DATA_BITS'(rx_s) << (DATA_BITS - 1));
                    if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = ST_PARITY;
`else
                        state_nxt = ST_STOP;
`endif
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    par_nxt   = rx_s;
                    state_nxt = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    if (rx_s) begin
                        // Leave at mid-stop so a back-to-back start edge is caught
                        data_nxt  = shift;
                        valid_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_nxt  = (^shift) ^ par_bit;
`endif
                        state_nxt = ST_IDLE;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                // A held-low line (break) must not decode as a stream of zero words
                if (rx_s) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx at 16 clocks per bit,
// 8 data bits. Frames are driven on the falling clock edge and outputs are
// sampled on the falling edge. Builds with or without UART_RX_PARITY_EN.
module tb_uart_rx;

    localparam int unsigned CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int LAT = 155 + (PAR ? 16 : 0);

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_busy;
`ifdef UART_RX_PARITY_EN
    logic       o_parity_err;
`endif

    uart_rx #(
        .CLOCK_RATE    (1600000),
        .BAUD_RATE     (100000),
        .DATA_BITS     (8),
        .CYCLES_PER_BIT(CPB)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_rx        (rx),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_frame_err (o_frame_err),
`ifdef UART_RX_PARITY_EN
        .o_parity_err(o_parity_err),
`endif
        .o_busy      (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: running totals only, tests compare deltas
    int         valid_total     = 0;
    int         ferr_total      = 0;
    int         both_total      = 0;
    int         perr_total      = 0;
    int         perr_with_valid = 0;
    int         last_valid_cyc  = 0;
    logic [7:0] vlog [0:63];

    always @(negedge clk) begin
        if (!rst) begin
            if (o_valid) begin
                vlog[valid_total % 64] = o_data;
                valid_total            = valid_total + 1;
                last_valid_cyc         = cyc;
            end
            if (o_frame_err) ferr_total = ferr_total + 1;
            if (o_valid && o_frame_err) both_total = both_total + 1;
`ifdef UART_RX_PARITY_EN
            if (o_parity_err) begin
                perr_total = perr_total + 1;
                if (o_valid) perr_with_valid = perr_with_valid + 1;
            end
`endif
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    int fall_cyc = 0;

    // One frame: start, 8 data bits LSB first, optional parity, stop
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
        rx       = 1'b0;
        fall_cyc = cyc;
        wait_cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_cycles(CPB);
        end
        if (PAR) begin
            rx = par_b;
            wait_cycles(CPB);
        end
        rx = stop_b;
        wait_cycles(CPB);
    endtask

    int v0, f0, lat;

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        wait_cycles(4);
        check("reset_data",  32'(o_data),      32'h0);
        check("reset_valid", 32'(o_valid),     32'h0);
        check("reset_ferr",  32'(o_frame_err), 32'h0);
        check("reset_busy",  32'(o_busy),      32'h0);
        rst = 1'b0;
        wait_cycles(5);

        // Single frame 0x55
        v0 = valid_total; f0 = ferr_total;
        send_frame(8'h55, 1'b1, ^8'h55);
        wait_cycles(20);
        check("f55_valid_cnt", 32'(valid_total - v0), 32'd1);
        check("f55_data",      32'(o_data),           32'h55);
        check("f55_ferr_cnt",  32'(ferr_total - f0),  32'd0);
        check("f55_busy_idle", 32'(o_busy),           32'h0);
        lat = last_valid_cyc - fall_cyc;
        check("f55_latency_ok", 32'((lat >= LAT - 1) && (lat <= LAT + 1)), 32'd1);

        // Start-bit glitch of 4 cycles
        v0 = valid_total; f0 = ferr_total;
        rx = 1'b0;
        wait_cycles(4);
        rx = 1'b1;
        check("glitch_busy_hi", 32'(o_busy), 32'h1);
        wait_cycles(10);
        check("glitch_busy_lo", 32'(o_busy), 32'h0);
        wait_cycles(20);
        check("glitch_valid_cnt", 32'(valid_total - v0), 32'd0);
        check("glitch_ferr_cnt",  32'(ferr_total - f0),  32'd0);
        check("glitch_data",      32'(o_data),           32'h55);

        // Back-to-back 0xA3, 0x0F
        v0 = valid_total; f0 = ferr_total;
        send_frame(8'hA3, 1'b1, ^8'hA3);
        send_frame(8'h0F, 1'b1, ^8'h0F);
        wait_cycles(30);
        check("b2b_valid_cnt", 32'(valid_total - v0), 32'd2);
        check("b2b_first",     32'(vlog[v0 % 64]),     32'hA3);
        check("b2b_second",    32'(vlog[(v0 + 1) % 64]), 32'h0F);
        check("b2b_ferr_cnt",  32'(ferr_total - f0),  32'd0);

        // Bad stop bit on 0x3C, line held low (break)
        v0 = valid_total; f0 = ferr_total;
        send_frame(8'h3C, 1'b0, ^8'h3C);
        wait_cycles(40);
        check("ferr_cnt",       32'(ferr_total - f0),  32'd1);
        check("ferr_valid_cnt", 32'(valid_total - v0), 32'd0);
        check("ferr_data_held", 32'(o_data),           32'h0F);
        check("ferr_busy_held", 32'(o_busy),           32'h1);
        rx = 1'b1;
        wait_cycles(1);
        check("ferr_busy_rel1", 32'(o_busy), 32'h1);
        wait_cycles(5);
        check("ferr_busy_rel6", 32'(o_busy), 32'h0);
        wait_cycles(20);
        check("ferr_cnt_final", 32'(ferr_total - f0), 32'd1);

        // Reset during data bit 4 of 0xFF, then 0x81
        v0 = valid_total; f0 = ferr_total;
        rx = 1'b0;
        wait_cycles(CPB);
        rx = 1'b1;
        wait_cycles(4 * CPB + 8);
        rst = 1'b1;
        wait_cycles(1);
        check("midrst_data",  32'(o_data),      32'h0);
        check("midrst_valid", 32'(o_valid),     32'h0);
        check("midrst_ferr",  32'(o_frame_err), 32'h0);
        check("midrst_busy",  32'(o_busy),      32'h0);
        wait_cycles(4);
        rst = 1'b0;
        wait_cycles(200);
        check("abort_valid_cnt", 32'(valid_total - v0), 32'd0);
        check("abort_ferr_cnt",  32'(ferr_total - f0),  32'd0);
        send_frame(8'h81, 1'b1, ^8'h81);
        wait_cycles(20);
        check("f81_valid_cnt", 32'(valid_total - v0), 32'd1);
        check("f81_data",      32'(o_data),           32'h81);

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones: parity bit 1 is correct even parity, 0 is not
        v0 = valid_total;
        check("par_none_before", 32'(perr_total), 32'd0);
        send_frame(8'h07, 1'b1, 1'b1);
        wait_cycles(20);
        check("par_good_valid", 32'(valid_total - v0), 32'd1);
        check("par_good_perr",  32'(perr_total),      32'd0);
        send_frame(8'h07, 1'b1, 1'b0);
        wait_cycles(20);
        check("par_bad_valid",  32'(valid_total - v0), 32'd2);
        check("par_bad_perr",   32'(perr_total),      32'd1);
        check("par_bad_with_v", 32'(perr_with_valid), 32'd1);
        check("par_bad_data",   32'(o_data),          32'h07);
`endif

        check("never_valid_and_ferr", 32'(both_total), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
